// File: rtl/wisc_pkg.sv
// Shared definitions for the branch condition path: condition codes, flag bit
// positions inside the Z/N/V masks, and the branch unit state encoding.
package wisc_pkg;

    localparam logic [2:0] CCC_NE     = 3'b000;
    localparam logic [2:0] CCC_EQ     = 3'b001;
    localparam logic [2:0] CCC_GT     = 3'b010;
    localparam logic [2:0] CCC_LT     = 3'b011;
    localparam logic [2:0] CCC_GTE    = 3'b100;
    localparam logic [2:0] CCC_LTE    = 3'b101;
    localparam logic [2:0] CCC_OVFL   = 3'b110;
    localparam logic [2:0] CCC_UNCOND = 3'b111;

    // Masks are packed {Z, N, V} so they line up with {ex_en_Z, ex_en_N, ex_en_V}
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HAZARD   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Combinational condition resolver: maps a ccc code plus the Z/N/V flags to a
// taken decision and the set of flags that decision depends on.
module cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       flag_v,
    output logic       taken,
    output logic [2:0] need_mask
);

    always_comb begin
        taken     = 1'b0;
        need_mask = 3'b000;
        case (ccc)
            CCC_NE: begin
                taken             = ~flag_z;
                need_mask[FLAG_Z] = 1'b1;
            end
            CCC_EQ: begin
                taken             = flag_z;
                need_mask[FLAG_Z] = 1'b1;
            end
            CCC_GT: begin
                taken             = ~flag_z & ~flag_n;
                need_mask[FLAG_Z] = 1'b1;
                need_mask[FLAG_N] = 1'b1;
            end
            CCC_LT: begin
                taken             = flag_n;
                need_mask[FLAG_N] = 1'b1;
            end
            CCC_GTE: begin
                taken             = flag_z | (~flag_z & ~flag_n);
                need_mask[FLAG_Z] = 1'b1;
                need_mask[FLAG_N] = 1'b1;
            end
            CCC_LTE: begin
                taken             = flag_n | flag_z;
                need_mask[FLAG_Z] = 1'b1;
                need_mask[FLAG_N] = 1'b1;
            end
            CCC_OVFL: begin
                taken             = flag_v;
                need_mask[FLAG_V] = 1'b1;
            end
            default: begin
                // Unconditional: depends on no flag, so it can never hazard
                taken     = 1'b1;
                need_mask = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Decode-side branch resolver: waits out flag hazards against EX, issues a held
// redirect toward fetch with a one-cycle flush, and keeps saturating statistics.
module branch_cond_unit
    import wisc_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int HAZ_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_ccc,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              ex_en_Z,
    input  logic              ex_en_N,
    input  logic              ex_en_V,
    input  logic              flag_Z,
    input  logic              flag_N,
    input  logic              flag_V,
    output logic              stall,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              redirect_ack,
    output logic              flush,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  taken_count
);

    // The cycle with count zero is itself the sampling cycle, so load one less
    // to get HAZ_CYCLES stall cycles before the flags are evaluated.
    localparam logic [1:0] WAIT_LOAD = 2'(HAZ_CYCLES - 1);

    state_t              state_reg;
    logic [1:0]          wait_reg;
    logic [2:0]          ccc_reg;
    logic [ADDR_W-1:0]   target_reg;
    logic                redirect_valid_reg;
    logic [ADDR_W-1:0]   redirect_pc_reg;
    logic                flush_reg;
    logic [CNT_W-1:0]    br_count_reg;
    logic [CNT_W-1:0]    taken_count_reg;

    logic [2:0]          eval_ccc;
    logic                eval_taken;
    logic [2:0]          need_mask;
    logic                hazard;
    logic [CNT_W-1:0]    br_count_next;
    logic [CNT_W-1:0]    taken_count_next;

    // While waiting out a hazard the latched condition is resolved; otherwise
    // the one being presented by decode.
    assign eval_ccc = (state_reg == ST_HAZARD) ? ccc_reg : br_ccc;

    cond_eval u_cond_eval (
        .ccc       (eval_ccc),
        .flag_z    (flag_Z),
        .flag_n    (flag_N),
        .flag_v    (flag_V),
        .taken     (eval_taken),
        .need_mask (need_mask)
    );

    assign hazard = |(need_mask & {ex_en_Z, ex_en_N, ex_en_V});

    assign br_count_next    = (&br_count_reg)    ? br_count_reg    : br_count_reg + 1'b1;
    assign taken_count_next = (&taken_count_reg) ? taken_count_reg : taken_count_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= ST_IDLE;
            wait_reg           <= 2'd0;
            ccc_reg            <= 3'd0;
            target_reg         <= '0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
            flush_reg          <= 1'b0;
            br_count_reg       <= '0;
            taken_count_reg    <= '0;
        end else begin
            flush_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (br_valid) begin
                        ccc_reg    <= br_ccc;
                        target_reg <= br_target;
                        if (hazard) begin
                            state_reg <= ST_HAZARD;
                            wait_reg  <= WAIT_LOAD;
                        end else begin
                            br_count_reg <= br_count_next;
                            if (eval_taken) begin
                                taken_count_reg    <= taken_count_next;
                                state_reg          <= ST_REDIRECT;
                                redirect_valid_reg <= 1'b1;
                                redirect_pc_reg    <= br_target;
                                flush_reg          <= 1'b1;
                            end
                        end
                    end
                end
                ST_HAZARD: begin
                    if (wait_reg == 2'd0) begin
                        br_count_reg <= br_count_next;
                        if (eval_taken) begin
                            taken_count_reg    <= taken_count_next;
                            state_reg          <= ST_REDIRECT;
                            redirect_valid_reg <= 1'b1;
                            redirect_pc_reg    <= target_reg;
                            flush_reg          <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        wait_reg <= wait_reg - 2'd1;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ack) begin
                        state_reg          <= ST_IDLE;
                        redirect_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg          <= ST_IDLE;
                    redirect_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign br_ready       = (state_reg == ST_IDLE);
    assign stall          = (state_reg != ST_IDLE);
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign flush          = flush_reg;
    assign br_count       = br_count_reg;
    assign taken_count    = taken_count_reg;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit: each step drives inputs, advances one
// clock and checks outputs 1 time unit after the rising edge.
module tb_branch_cond_unit;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 8;   // narrow counters so saturation is reachable quickly

    logic              clk = 1'b0;
    logic              rst_n;
    logic              br_valid;
    logic              br_ready;
    logic [2:0]        br_ccc;
    logic [ADDR_W-1:0] br_target;
    logic              ex_en_Z, ex_en_N, ex_en_V;
    logic              flag_Z, flag_N, flag_V;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              redirect_ack;
    logic              flush;
    logic [CNT_W-1:0]  br_count;
    logic [CNT_W-1:0]  taken_count;

    int total = 0;
    int bad   = 0;

    branch_cond_unit #(.ADDR_W(ADDR_W), .HAZ_CYCLES(1), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_ccc         (br_ccc),
        .br_target      (br_target),
        .ex_en_Z        (ex_en_Z),
        .ex_en_N        (ex_en_N),
        .ex_en_V        (ex_en_V),
        .flag_Z         (flag_Z),
        .flag_N         (flag_N),
        .flag_V         (flag_V),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ack   (redirect_ack),
        .flush          (flush),
        .br_count       (br_count),
        .taken_count    (taken_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic rdy, input logic stl,
                              input logic rv, input logic fl,
                              input logic [31:0] bc, input logic [31:0] tc);
        check({tag, ".br_ready"},       32'(br_ready),       32'(rdy));
        check({tag, ".stall"},          32'(stall),          32'(stl));
        check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
        check({tag, ".flush"},          32'(flush),          32'(fl));
        check({tag, ".br_count"},       32'(br_count),       bc);
        check({tag, ".taken_count"},    32'(taken_count),    tc);
        $display("step %s: ready=%0b stall=%0b rv=%0b pc=0x%04h flush=%0b br=%0d taken=%0d",
                 tag, br_ready, stall, redirect_valid, redirect_pc, flush, br_count, taken_count);
    endtask

    initial begin
        rst_n = 1'b0; br_valid = 1'b0; br_ccc = 3'd0; br_target = '0;
        ex_en_Z = 1'b0; ex_en_N = 1'b0; ex_en_V = 1'b0;
        flag_Z = 1'b0; flag_N = 1'b0; flag_V = 1'b0; redirect_ack = 1'b0;
        #1;
        check_outs("reset", 1, 0, 0, 0, 0, 0);
        check("reset.redirect_pc", 32'(redirect_pc), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // EQ with Z=1, no hazard: taken, redirect one cycle after accept
        br_valid = 1'b1; br_ccc = 3'b001; flag_Z = 1'b1; br_target = 16'h0040;
        check("eq.ready_before", 32'(br_ready), 32'd1);
        tick();
        br_valid = 1'b0; br_target = 16'h1234;
        check_outs("eq_taken", 0, 1, 1, 1, 1, 1);
        check("eq_taken.redirect_pc", 32'(redirect_pc), 32'h0040);

        // Hold redirect with ack low; a branch offered meanwhile must be ignored
        br_valid = 1'b1; br_ccc = 3'b111; br_target = 16'h0099;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs($sformatf("hold%0d", i), 0, 1, 1, 0, 1, 1);
            check($sformatf("hold%0d.redirect_pc", i), 32'(redirect_pc), 32'h0040);
        end
        br_valid = 1'b0;
        tick();
        check_outs("hold3", 0, 1, 1, 0, 1, 1);
        redirect_ack = 1'b1;
        tick();
        redirect_ack = 1'b0;
        check_outs("ack", 1, 0, 0, 0, 1, 1);

        // NE with Z=1: not taken, stays idle
        br_valid = 1'b1; br_ccc = 3'b000; flag_Z = 1'b1; br_target = 16'h0080;
        tick();
        br_valid = 1'b0;
        check_outs("ne_not_taken", 1, 0, 0, 0, 2, 1);

        // LT with N hazard: one stall cycle, flag_N commits to 1, redirect at +2
        br_valid = 1'b1; br_ccc = 3'b011; ex_en_N = 1'b1; flag_N = 1'b0; br_target = 16'h0A0A;
        tick();
        br_valid = 1'b0; ex_en_N = 1'b0; flag_N = 1'b1;
        check_outs("lt_hazard", 0, 1, 0, 0, 2, 1);
        redirect_ack = 1'b1;   // ack arrives in the redirect entry cycle
        tick();
        check_outs("lt_taken", 0, 1, 1, 1, 3, 2);
        check("lt_taken.redirect_pc", 32'(redirect_pc), 32'h0A0A);
        tick();
        redirect_ack = 1'b0;
        check_outs("lt_ack", 1, 0, 0, 0, 3, 2);

        // OVFL with only ex_en_Z: no hazard, V=0 so not taken immediately
        br_valid = 1'b1; br_ccc = 3'b110; ex_en_Z = 1'b1; flag_V = 1'b0;
        tick();
        br_valid = 1'b0; ex_en_Z = 1'b0;
        check_outs("ovfl_nohaz", 1, 0, 0, 0, 4, 2);

        // EQ hazard on Z, committed Z=0: stall then resolve not taken
        br_valid = 1'b1; br_ccc = 3'b001; ex_en_Z = 1'b1; flag_Z = 1'b1;
        tick();
        br_valid = 1'b0; ex_en_Z = 1'b0; flag_Z = 1'b0;
        check_outs("eq_hazard", 0, 1, 0, 0, 4, 2);
        tick();
        check_outs("eq_haz_nt", 1, 0, 0, 0, 5, 2);

        // Unconditional branches with ack held high until both counters saturate
        redirect_ack = 1'b1; ex_en_Z = 1'b1; ex_en_N = 1'b1; ex_en_V = 1'b1;
        for (int i = 0; i < 253; i++) begin
            br_valid = 1'b1; br_ccc = 3'b111; br_target = 16'(i);
            tick();
            br_valid = 1'b0;
            tick();
        end
        check_outs("saturated", 1, 0, 0, 0, 255, 255);
        br_valid = 1'b1; br_target = 16'hBEEF;
        tick();
        br_valid = 1'b0;
        check_outs("sat_taken", 0, 1, 1, 1, 255, 255);
        check("sat_taken.redirect_pc", 32'(redirect_pc), 32'hBEEF);
        tick();
        redirect_ack = 1'b0; ex_en_Z = 1'b0; ex_en_V = 1'b0;

        // Async reset in the middle of a hazard wait discards the branch
        br_valid = 1'b1; br_ccc = 3'b011; ex_en_N = 1'b1; flag_N = 1'b0; br_target = 16'h0777;
        tick();
        br_valid = 1'b0; ex_en_N = 1'b0; flag_N = 1'b1;
        check_outs("pre_reset_haz", 0, 1, 0, 0, 255, 255);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_reset", 1, 0, 0, 0, 0, 0);
        check("async_reset.redirect_pc", 32'(redirect_pc), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check_outs("post_reset", 1, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
